// File: rtl/serial_eq_cmp_if.sv
// Bit-pair input channel and result output channel for serial_eq_cmp.
// out_diff_count exists only when SERIAL_EQ_DIFFCNT_EN is defined.
interface serial_eq_cmp_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned IDXW = $clog2(WIDTH + 1);

  logic            in_valid;
  logic            in_ready;
  logic            in_a;
  logic            in_b;
  logic            out_valid;
  logic            out_ready;
  logic            out_eq;
  logic [IDXW-1:0] out_first_diff;
`ifdef SERIAL_EQ_DIFFCNT_EN
  logic [IDXW-1:0] out_diff_count;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_eq, out_first_diff, out_diff_count
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_eq, out_first_diff, out_diff_count
  );
`else
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_eq, out_first_diff
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_eq, out_first_diff
  );
`endif
endinterface

// File: rtl/serial_eq_cmp.sv
// Serial word-equality comparator: ANDs per-bit XNOR over WIDTH LSB-first bit pairs and
// tracks the first mismatch. Define SERIAL_EQ_DIFFCNT_EN to add the mismatch-count output.
module serial_eq_cmp #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned IDXW  = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  serial_eq_cmp_if.slave bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [IDXW-1:0] bit_idx;
  logic [IDXW-1:0] first_diff;
  logic [IDXW-1:0] first_diff_upd;
  logic [IDXW-1:0] out_first_diff_q;
  logic            eq_acc;
  logic            eq_upd;
  logic            out_eq_q;
  logic            xnor_bit;
  logic            accept;
  logic            result_hs;
  logic            last_bit;

  g_XNOR u_xnor (
    .a (bus.in_a),
    .b (bus.in_b),
    .y (xnor_bit)
  );

  // Handshake qualifiers and the accumulator values after absorbing the current pair.
  always_comb begin
    accept         = bus.in_valid && (state_q == ACCUM);
    result_hs      = bus.out_ready && (state_q == HOLD);
    last_bit       = (bit_idx == IDXW'(WIDTH - 1));
    eq_upd         = eq_acc & xnor_bit;
    first_diff_upd = (eq_acc && !xnor_bit) ? bit_idx : first_diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (accept && last_bit) state_d = HOLD;
        HOLD:    if (result_hs)          state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      ACCUM:   bus.in_ready  = 1'b1;
      HOLD:    bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b0;
    endcase
  end

  // Word accumulator; flush outranks a same-cycle accept or result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx          <= '0;
      eq_acc           <= 1'b1;
      first_diff       <= IDXW'(WIDTH);
      out_eq_q         <= 1'b0;
      out_first_diff_q <= '0;
    end else if (flush) begin
      bit_idx    <= '0;
      eq_acc     <= 1'b1;
      first_diff <= IDXW'(WIDTH);
    end else if (accept) begin
      eq_acc     <= eq_upd;
      first_diff <= first_diff_upd;
      if (last_bit) begin
        bit_idx          <= '0;
        out_eq_q         <= eq_upd;
        out_first_diff_q <= first_diff_upd;
      end else begin
        bit_idx <= bit_idx + IDXW'(1);
      end
    end else if (result_hs) begin
      eq_acc     <= 1'b1;
      first_diff <= IDXW'(WIDTH);
    end
  end

  assign bus.out_eq         = out_eq_q;
  assign bus.out_first_diff = out_first_diff_q;

`ifdef SERIAL_EQ_DIFFCNT_EN
  logic [IDXW-1:0] diff_cnt;
  logic [IDXW-1:0] diff_cnt_upd;
  logic [IDXW-1:0] out_diff_count_q;

  always_comb begin
    diff_cnt_upd = diff_cnt + IDXW'(!xnor_bit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_cnt         <= '0;
      out_diff_count_q <= '0;
    end else if (flush) begin
      diff_cnt <= '0;
    end else if (accept) begin
      diff_cnt <= diff_cnt_upd;
      if (last_bit) begin
        out_diff_count_q <= diff_cnt_upd;
      end
    end else if (result_hs) begin
      diff_cnt <= '0;
    end
  end

  assign bus.out_diff_count = out_diff_count_q;

  a_eq_iff_zero_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    bus.out_valid |-> (bus.out_eq == (bus.out_diff_count == '0)));
`endif

  // A held result must not move until it is taken or flushed.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready && !flush) |=>
      (bus.out_valid && $stable(bus.out_eq) && $stable(bus.out_first_diff)));

  a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
    bit_idx <= IDXW'(WIDTH - 1));

endmodule

// Per-bit equality stage.
module g_XNOR (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a ^ b);
endmodule

// File: tb/tb_serial_eq_cmp.sv
// Scoreboard bench for serial_eq_cmp: words are modelled when driven, results checked on handshake.
module tb_serial_eq_cmp;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned IDXW  = $clog2(WIDTH + 1);

  typedef struct packed {
    logic            eq;
    logic [IDXW-1:0] fd;
    logic [IDXW-1:0] cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   waits = 0;
  exp_t sb[$];

  serial_eq_cmp_if #(.WIDTH(WIDTH)) bus ();

  serial_eq_cmp #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.eq  = 1'b1;
    e.fd  = IDXW'(WIDTH);
    e.cnt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (a[i] !== b[i]) begin
        if (e.eq) e.fd = IDXW'(i);
        e.eq  = 1'b0;
        e.cnt = e.cnt + IDXW'(1);
      end
    end
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the edge that accepted the pair.
  task automatic send_bit(input logic a, input logic b);
    logic rdy;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    waits        = 0;
    do begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (!rdy) waits++;
    end while (!rdy && waits < 200);
    if (!rdy) chk("in_ready_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input bit push, output int first_waits);
    first_waits = 0;
    if (push) sb.push_back(model(a, b));
    for (int i = 0; i < int'(WIDTH); i++) begin
      send_bit(a[i], b[i]);
      if (i == 0) first_waits = waits;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Result monitor: mid-cycle sample of the handshake that the next rising edge completes.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready && !flush) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("out_eq", 32'(bus.out_eq), 32'(e.eq));
        chk("out_first_diff", 32'(bus.out_first_diff), 32'(e.fd));
`ifdef SERIAL_EQ_DIFFCNT_EN
        chk("out_diff_count", 32'(bus.out_diff_count), 32'(e.cnt));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fw;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    bus.in_valid  = 1'b0;
    bus.in_a      = 1'b0;
    bus.in_b      = 1'b0;
    bus.out_ready = 1'b1;

    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_eq", 32'(bus.out_eq), 32'd0);
    chk("rst_out_first_diff", 32'(bus.out_first_diff), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Back-to-back words with in_valid held high.
    send_word(16'hA5C3, 16'hA5C3, 1'b1, fw);
    chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
    chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    send_word(16'h00F0, 16'h0070, 1'b1, fw);
    chk("next_word_wait", 32'(fw), 32'd1);
    send_word(16'hFFFF, 16'h0000, 1'b1, fw);
    chk("next_word_wait2", 32'(fw), 32'd1);
    bus.in_valid = 1'b0;
    idle(1);

    // Result stalled while upstream keeps offering bits.
    bus.out_ready = 1'b0;
    send_word(16'h1234, 16'h1234 ^ 16'h0410, 1'b1, fw);
    for (int k = 0; k < 5; k++) begin
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_out_eq", 32'(bus.out_eq), 32'(sb[0].eq));
      chk("stall_out_first_diff", 32'(bus.out_first_diff), 32'(sb[0].fd));
      idle(1);
    end
    bus.out_ready = 1'b1;
    send_word(16'h0001, 16'h0000, 1'b1, fw);
    chk("resume_wait", 32'(fw), 32'd1);
    bus.in_valid = 1'b0;
    idle(1);

    // Flush mid-word: mismatch at bit 3 must not leak into the next word.
    for (int i = 0; i < 9; i++) begin
      ra = 16'h01FF;
      rb = 16'h01F7;
      send_bit(ra[i], rb[i]);
    end
    bus.in_valid = 1'b0;
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    send_word(16'hBEEF, 16'hBEEF, 1'b1, fw);
    bus.in_valid = 1'b0;
    idle(1);

    // Flush while a result is held discards it.
    bus.out_ready = 1'b0;
    send_word(16'h0F0F, 16'h0F00, 1'b0, fw);
    bus.in_valid = 1'b0;
    chk("pre_flush_hold", 32'(bus.out_valid), 32'd1);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    chk("flush_hold_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_hold_in_ready", 32'(bus.in_ready), 32'd1);

    // Asynchronous reset pulse during HOLD.
    send_word(16'h5555, 16'h5555, 1'b0, fw);
    bus.in_valid = 1'b0;
    chk("pre_rst_hold", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle(1);
    send_word(16'h8000, 16'h0000, 1'b1, fw);
    bus.in_valid = 1'b0;
    idle(2);
    chk("post_rst_one_result", 32'(sb.size()), 32'd0);

    // Random words.
    for (int w = 0; w < 4; w++) begin
      ra = WIDTH'($urandom);
      rb = (w == 0) ? ra : WIDTH'($urandom);
      send_word(ra, rb, 1'b1, fw);
    end
    bus.in_valid = 1'b0;
    idle(3);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
